// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the conditional-execution control pipeline:
// ARM condition codes, NZCV bit positions and stage payload structs.
package pipe_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Execute-stage controls (ALU fields are parameterised and kept apart)
  typedef struct packed {
    logic       valid;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       branch;
    logic [1:0] flagw;
    logic [3:0] cond;
  } ctrl_e_t;

  typedef struct packed {
    logic pcs;
    logic regw;
    logic memw;
    logic memtoreg;
  } ctrl_m_t;

  typedef struct packed {
    logic pcs;
    logic regw;
    logic memtoreg;
  } ctrl_w_t;

endpackage

// File: rtl/pipe_cond_ctrl_cond_check.sv
// Combinational ARM condition-field evaluator against the NZCV flags.
module cond_check
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondPass
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondPass = 1'b0;
    case (Cond)
      COND_EQ: CondPass = z;
      COND_NE: CondPass = ~z;
      COND_CS: CondPass = c;
      COND_CC: CondPass = ~c;
      COND_MI: CondPass = n;
      COND_PL: CondPass = ~n;
      COND_VS: CondPass = v;
      COND_VC: CondPass = ~v;
      COND_HI: CondPass = c & ~z;
      COND_LS: CondPass = ~c | z;
      COND_GE: CondPass = (n == v);
      COND_LT: CondPass = (n != v);
      COND_GT: CondPass = ~z & (n == v);
      COND_LE: CondPass = z | (n != v);
      COND_AL: CondPass = 1'b1;
      default: CondPass = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_cond_ctrl.sv
// Decode->Execute->Memory->Writeback control pipeline with conditional
// execution, partial NZCV writes and a saturating condition-fail counter.
module pipe_cond_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 2,
  parameter int unsigned ALUSRC_W  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidD,
  input  logic                 PCSD,
  input  logic                 RegWD,
  input  logic                 MemWD,
  input  logic                 MemtoRegD,
  input  logic                 BranchD,
  input  logic [1:0]           FlagWD,
  input  logic [3:0]           CondD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [ALUSRC_W-1:0]  ALUSrcD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic [3:0]           ALUFlags,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [ALUSRC_W-1:0]  ALUSrcE,
  output logic                 MemtoRegE,
  output logic                 CondExE,
  output logic                 BranchTakenE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 MemtoRegM,
  output logic                 PCSrcW,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [3:0]           Flags,
  output logic [CNT_W-1:0]     CondFailCnt
);

  ctrl_e_t                e_q, e_d;
  logic [ALUCTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [ALUSRC_W-1:0]    alu_src_q, alu_src_d;
  ctrl_m_t                m_q, m_d;
  ctrl_w_t                w_q, w_d;
  logic [3:0]             flags_q, flags_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cond_pass;
  logic                   cond_ex;

  cond_check u_cond_check (
    .Cond     (e_q.cond),
    .Flags    (flags_q),
    .CondPass (cond_pass)
  );

  assign cond_ex = e_q.valid & cond_pass;

  always_comb begin
    e_d        = e_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_src_d  = alu_src_q;
    m_d        = '0;
    w_d        = '0;
    flags_d    = flags_q;
    cnt_d      = cnt_q;

    // Execute register: flush beats stall beats load
    if (FlushE) begin
      e_d        = '0;
      alu_ctrl_d = '0;
      alu_src_d  = '0;
    end else if (!StallE) begin
      e_d.valid    = ValidD;
      e_d.pcs      = PCSD;
      e_d.regw     = RegWD;
      e_d.memw     = MemWD;
      e_d.memtoreg = MemtoRegD;
      e_d.branch   = BranchD;
      e_d.flagw    = FlagWD;
      e_d.cond     = CondD;
      alu_ctrl_d   = ALUControlD;
      alu_src_d    = ALUSrcD;
    end

    // A stalled Execute instruction has not left E, so M sees a bubble
    if (!StallE) begin
      m_d.pcs      = e_q.pcs  & cond_ex;
      m_d.regw     = e_q.regw & cond_ex;
      m_d.memw     = e_q.memw & cond_ex;
      m_d.memtoreg = e_q.memtoreg;
    end

    w_d.pcs      = m_q.pcs;
    w_d.regw     = m_q.regw;
    w_d.memtoreg = m_q.memtoreg;

    if (!StallE && cond_ex) begin
      if (e_q.flagw[1]) begin
        flags_d[FLAG_N] = ALUFlags[FLAG_N];
        flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
      end
      if (e_q.flagw[0]) begin
        flags_d[FLAG_C] = ALUFlags[FLAG_C];
        flags_d[FLAG_V] = ALUFlags[FLAG_V];
      end
    end

    if (e_q.valid && !cond_pass && !StallE && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q        <= '0;
      alu_ctrl_q <= '0;
      alu_src_q  <= '0;
      m_q        <= '0;
      w_q        <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
    end else begin
      e_q        <= e_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_src_q  <= alu_src_d;
      m_q        <= m_d;
      w_q        <= w_d;
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ALUControlE  = alu_ctrl_q;
  assign ALUSrcE      = alu_src_q;
  assign MemtoRegE    = e_q.memtoreg;
  assign CondExE      = cond_ex;
  assign BranchTakenE = e_q.branch & cond_ex;
  assign RegWriteM    = m_q.regw;
  assign MemWriteM    = m_q.memw;
  assign MemtoRegM    = m_q.memtoreg;
  assign PCSrcW       = w_q.pcs;
  assign RegWriteW    = w_q.regw;
  assign MemtoRegW    = w_q.memtoreg;
  assign Flags        = flags_q;
  assign CondFailCnt  = cnt_q;

endmodule

// File: tb/tb_pipe_cond_ctrl.sv
// Scoreboard bench for pipe_cond_ctrl: a cycle model predicts outputs as
// stimulus is applied; predictions are popped and compared after each edge.
module tb_pipe_cond_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ValidD, PCSD, RegWD, MemWD, MemtoRegD, BranchD;
  logic [1:0] FlagWD;
  logic [3:0] CondD;
  logic [1:0] ALUControlD, ALUSrcD;
  logic       StallE, FlushE;
  logic [3:0] ALUFlags;

  logic [1:0]  ALUControlE, ALUSrcE;
  logic        MemtoRegE, CondExE, BranchTakenE, RegWriteM, MemWriteM, MemtoRegM;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [3:0]  Flags;
  logic [15:0] CondFailCnt;

  logic [1:0]  s_alu, s_src;
  logic        s_mtre, s_cex, s_bt, s_rwm, s_mwm, s_mtrm, s_pcw, s_rww, s_mtrw;
  logic [3:0]  s_flags;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  pipe_cond_ctrl dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .PCSD(PCSD), .RegWD(RegWD),
    .MemWD(MemWD), .MemtoRegD(MemtoRegD), .BranchD(BranchD), .FlagWD(FlagWD),
    .CondD(CondD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .StallE(StallE), .FlushE(FlushE), .ALUFlags(ALUFlags),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcW(PCSrcW),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .Flags(Flags),
    .CondFailCnt(CondFailCnt)
  );

  pipe_cond_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .ValidD(ValidD), .PCSD(PCSD), .RegWD(RegWD),
    .MemWD(MemWD), .MemtoRegD(MemtoRegD), .BranchD(BranchD), .FlagWD(FlagWD),
    .CondD(CondD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .StallE(StallE), .FlushE(FlushE), .ALUFlags(ALUFlags),
    .ALUControlE(s_alu), .ALUSrcE(s_src), .MemtoRegE(s_mtre),
    .CondExE(s_cex), .BranchTakenE(s_bt), .RegWriteM(s_rwm),
    .MemWriteM(s_mwm), .MemtoRegM(s_mtrm), .PCSrcW(s_pcw),
    .RegWriteW(s_rww), .MemtoRegW(s_mtrw), .Flags(s_flags),
    .CondFailCnt(s_cnt)
  );

  typedef struct packed {
    logic [1:0]  alu;
    logic [1:0]  src;
    logic        mtre, cex, bt, rwm, mwm, mtrm, pcw, rww, mtrw;
    logic [3:0]  flags;
    logic [15:0] cnt;
    logic [1:0]  cnts;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // model state
  logic       me_valid, me_pcs, me_regw, me_memw, me_mtr, me_br;
  logic [1:0] me_fw, me_alu, me_src;
  logic [3:0] me_cond;
  logic       mm_pcs, mm_regw, mm_memw, mm_mtr;
  logic       mw_pcs, mw_regw, mw_mtr;
  logic [3:0] m_flags;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ARM conditions pair up: odd codes are the inverse of the even code below
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic b;
    case (c[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] & ~f[2];
      3'd5: b = (f[3] == f[0]);
      3'd6: b = ~f[2] & (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    if (c == 4'b1110) return 1'b1;
    return b ^ c[0];
  endfunction

  task automatic model_reset();
    {me_valid, me_pcs, me_regw, me_memw, me_mtr, me_br} = '0;
    me_fw = '0; me_alu = '0; me_src = '0; me_cond = '0;
    {mm_pcs, mm_regw, mm_memw, mm_mtr} = '0;
    {mw_pcs, mw_regw, mw_mtr} = '0;
    m_flags = '0; m_cnt = '0; m_cnts = '0;
  endtask

  task automatic model_advance(output exp_t e);
    logic pass, cex;
    pass = model_pass(me_cond, m_flags);
    cex  = me_valid & pass;
    mw_pcs = mm_pcs; mw_regw = mm_regw; mw_mtr = mm_mtr;
    if (!StallE) begin
      if (cex && me_fw[1]) m_flags[3:2] = ALUFlags[3:2];
      if (cex && me_fw[0]) m_flags[1:0] = ALUFlags[1:0];
      if (me_valid && !pass) begin
        if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
        if (m_cnts != 2'd3) m_cnts = m_cnts + 2'd1;
      end
      mm_pcs = me_pcs & cex; mm_regw = me_regw & cex;
      mm_memw = me_memw & cex; mm_mtr = me_mtr;
    end else begin
      {mm_pcs, mm_regw, mm_memw, mm_mtr} = '0;
    end
    if (FlushE) begin
      {me_valid, me_pcs, me_regw, me_memw, me_mtr, me_br} = '0;
      me_fw = '0; me_alu = '0; me_src = '0; me_cond = '0;
    end else if (!StallE) begin
      me_valid = ValidD; me_pcs = PCSD; me_regw = RegWD; me_memw = MemWD;
      me_mtr = MemtoRegD; me_br = BranchD; me_fw = FlagWD; me_cond = CondD;
      me_alu = ALUControlD; me_src = ALUSrcD;
    end
    e.alu = me_alu; e.src = me_src; e.mtre = me_mtr;
    e.cex = me_valid & model_pass(me_cond, m_flags);
    e.bt = me_br & e.cex;
    e.rwm = mm_regw; e.mwm = mm_memw; e.mtrm = mm_mtr;
    e.pcw = mw_pcs; e.rww = mw_regw; e.mtrw = mw_mtr;
    e.flags = m_flags; e.cnt = m_cnt; e.cnts = m_cnts;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL sb_underflow: no expected entry at %0t", $time);
      return;
    end
    e = sb_q.pop_front();
    check("ALUControlE",  32'(ALUControlE),  32'(e.alu));
    check("ALUSrcE",      32'(ALUSrcE),      32'(e.src));
    check("MemtoRegE",    32'(MemtoRegE),    32'(e.mtre));
    check("CondExE",      32'(CondExE),      32'(e.cex));
    check("BranchTakenE", 32'(BranchTakenE), 32'(e.bt));
    check("RegWriteM",    32'(RegWriteM),    32'(e.rwm));
    check("MemWriteM",    32'(MemWriteM),    32'(e.mwm));
    check("MemtoRegM",    32'(MemtoRegM),    32'(e.mtrm));
    check("PCSrcW",       32'(PCSrcW),       32'(e.pcw));
    check("RegWriteW",    32'(RegWriteW),    32'(e.rww));
    check("MemtoRegW",    32'(MemtoRegW),    32'(e.mtrw));
    check("Flags",        32'(Flags),        32'(e.flags));
    check("CondFailCnt",  32'(CondFailCnt),  32'(e.cnt));
    check("CondFailCnt2", 32'(s_cnt),        32'(e.cnts));
  endtask

  task automatic step(input logic v, pcs, rw, mw, mtr, br, input logic [1:0] fw,
                      input logic [3:0] cd, input logic [1:0] ac, as,
                      input logic st, fl, input logic [3:0] af);
    exp_t e;
    ValidD = v; PCSD = pcs; RegWD = rw; MemWD = mw; MemtoRegD = mtr; BranchD = br;
    FlagWD = fw; CondD = cd; ALUControlD = ac; ALUSrcD = as;
    StallE = st; FlushE = fl; ALUFlags = af;
    model_advance(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic bub(input logic [3:0] af);
    step(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 0, af);
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] acc;
    acc = 32'({ALUControlE, ALUSrcE, MemtoRegE, CondExE, BranchTakenE, RegWriteM,
               MemWriteM, MemtoRegM, PCSrcW, RegWriteW, MemtoRegW, Flags});
    check({tag, "_ctl"}, acc, 32'd0);
    check({tag, "_cnt"}, 32'(CondFailCnt), 32'd0);
    check({tag, "_cnt2"}, 32'(s_cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    ValidD = 1; PCSD = 1; RegWD = 1; MemWD = 1; MemtoRegD = 1; BranchD = 1;
    FlagWD = 2'b11; CondD = 4'b1110; ALUControlD = 2'b11; ALUSrcD = 2'b11;
    StallE = 0; FlushE = 0; ALUFlags = 4'b1111;
    model_reset();
    #22;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // latency through E, M, W
    step(1, 0, 1, 0, 0, 0, 2'b00, 4'b1110, 2'b01, 2'b10, 0, 0, 4'b0000);
    bub(4'b0000);
    check("lat_RegWriteM", 32'(RegWriteM), 32'd1);
    bub(4'b0000);
    check("lat_RegWriteW", 32'(RegWriteW), 32'd1);

    // ADDS sets Z, then BEQ taken
    step(1, 0, 1, 0, 0, 0, 2'b11, 4'b1110, 2'b00, 2'b00, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 0, 1, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 0, 4'b0100);
    check("eq_Flags", 32'(Flags), 32'h4);
    check("eq_BranchTakenE", 32'(BranchTakenE), 32'd1);
    bub(4'b0000);
    bub(4'b0000);
    check("eq_PCSrcW", 32'(PCSrcW), 32'd1);

    // ADDS clears Z, then BEQ not taken
    step(1, 0, 1, 0, 0, 0, 2'b11, 4'b1110, 2'b00, 2'b00, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 0, 1, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 0, 4'b0000);
    check("ne_BranchTakenE", 32'(BranchTakenE), 32'd0);
    bub(4'b0000);
    check("ne_CondFailCnt", 32'(CondFailCnt), 32'd1);
    bub(4'b0000);
    check("ne_PCSrcW", 32'(PCSrcW), 32'd0);

    // partial flag write: only N,Z
    step(1, 0, 0, 0, 0, 0, 2'b11, 4'b1110, 2'b00, 2'b00, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 0, 0, 2'b10, 4'b1110, 2'b00, 2'b00, 0, 0, 4'b1111);
    check("pw_Flags_all", 32'(Flags), 32'hf);
    bub(4'b0000);
    check("pw_Flags_nz", 32'(Flags), 32'h3);

    // stall holds E and bubbles M; flush+stall squashes
    step(1, 0, 1, 0, 1, 0, 2'b00, 4'b1110, 2'b10, 2'b01, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 0, 0, 2'b00, 4'b1110, 2'b01, 2'b10, 1, 0, 4'b0000);
    check("st1_ALUControlE", 32'(ALUControlE), 32'h2);
    check("st1_RegWriteM", 32'(RegWriteM), 32'd0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 4'b1110, 2'b01, 2'b10, 1, 0, 4'b0000);
    check("st2_ALUSrcE", 32'(ALUSrcE), 32'h1);
    check("st2_RegWriteM", 32'(RegWriteM), 32'd0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 4'b1110, 2'b01, 2'b10, 1, 1, 4'b0000);
    check("fl_CondExE", 32'(CondExE), 32'd0);
    check("fl_RegWriteM", 32'(RegWriteM), 32'd0);
    // failing instruction held by stall must not count
    step(1, 0, 1, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 1, 0, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 1, 1, 4'b0000);
    bub(4'b0000);
    check("stfl_CondFailCnt", 32'(CondFailCnt), 32'd1);

    // NV store is gated and leaves flags alone
    step(1, 0, 0, 1, 0, 0, 2'b11, 4'b1111, 2'b00, 2'b00, 0, 0, 4'b0000);
    bub(4'b1010);
    check("nv_MemWriteM", 32'(MemWriteM), 32'd0);
    check("nv_Flags", 32'(Flags), 32'h3);

    // asynchronous reset mid-pipeline
    step(1, 1, 1, 0, 0, 0, 2'b11, 4'b1110, 2'b11, 2'b11, 0, 0, 4'b0000);
    step(1, 0, 0, 1, 1, 0, 2'b11, 4'b1110, 2'b10, 2'b01, 0, 0, 4'b1001);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    bub(4'b1111);
    check("post_reset_Flags", 32'(Flags), 32'h0);

    // saturation of the narrow counter
    for (int i = 0; i < 5; i++)
      step(1, 0, 1, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 0, 4'b0000);
    bub(4'b0000);
    check("sat_cnt2", 32'(s_cnt), 32'd3);
    check("sat_cnt16", 32'(CondFailCnt), 32'd5);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
           2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) == 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
